// File: rtl/ldmx_daq_pkg.sv
// Shared types and constants for the LDMX DAQ DMA arbitration blocks.
package ldmx_daq_pkg;

  localparam int unsigned GRANT_W = 3;

  localparam logic [63:0] ABORT_WORD_BASE = 64'hDEAD_BEEF_0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    ABORT,
    DRAIN
  } arb_state_t;

endpackage

// File: rtl/ldmx_daq_dma_arbiter_if.sv
// Source-side and host-side stream signals of the DAQ DMA arbiter.
// The master modport is the arbiter's view; slave is the surrounding fabric.
interface ldmx_daq_dma_arbiter_if #(
  parameter int unsigned NSRC = 4
);

  logic [NSRC-1:0]    src_enable;
  logic [NSRC-1:0]    src_valid;
  logic [64*NSRC-1:0] src_data;
  logic [NSRC-1:0]    src_last;
  logic [NSRC-1:0]    src_ready;

  logic               dma_valid;
  logic [63:0]        dma_data;
  logic               dma_done;
  logic               dma_ready;

  modport master (
    input  src_enable, src_valid, src_data, src_last, dma_ready,
    output src_ready, dma_valid, dma_data, dma_done
  );

  modport slave (
    output src_enable, src_valid, src_data, src_last, dma_ready,
    input  src_ready, dma_valid, dma_data, dma_done
  );

endinterface

// File: rtl/ldmx_rr_pick.sv
// Combinational round-robin picker: first requester strictly after
// last_grant, wrapping modulo NSRC.
module ldmx_rr_pick
  import ldmx_daq_pkg::*;
#(
  parameter int unsigned NSRC = 4
) (
  input  logic [NSRC-1:0]    req,
  input  logic [GRANT_W-1:0] last_grant,
  output logic [GRANT_W-1:0] pick,
  output logic               any_req
);

  always_comb begin
    pick    = '0;
    any_req = 1'b0;
    // Offsets 1..NSRC visit every index once, ending on last_grant itself.
    for (int unsigned k = 1; k <= NSRC; k++) begin
      for (int unsigned j = 0; j < NSRC; j++) begin
        if (!any_req && req[j] && ((32'(last_grant) + k) % NSRC) == j) begin
          any_req = 1'b1;
          pick    = GRANT_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/ldmx_daq_dma_arbiter.sv
// Round-robin event arbiter sharing one host DMA stream among NSRC sources.
// Define LDMX_DAQ_ARB_TIMEOUT_EN to enable mid-event stall abort and drain.
module ldmx_daq_dma_arbiter
  import ldmx_daq_pkg::*;
#(
  parameter int unsigned NSRC       = 4,
  parameter int unsigned TIMEOUT    = 1024,
  parameter logic [63:0] ABORT_WORD = ABORT_WORD_BASE
) (
  input  logic                  dma_clk,
  input  logic                  reset,
  ldmx_daq_dma_arbiter_if.master bus,
  output logic [GRANT_W-1:0]    grant_id,
  output logic                  busy,
  output logic [31:0]           event_count,
  output logic [15:0]           abort_count
);

  arb_state_t         state;
  logic [NSRC-1:0]    req;
  logic [NSRC-1:0]    g_sel;
  logic               g_valid;
  logic [63:0]        g_data;
  logic               g_last;
  logic [GRANT_W-1:0] pick_id;
  logic               pick_any;
  logic               xfer;

  assign req  = bus.src_valid & bus.src_enable;
  assign busy = (state != IDLE);
  assign xfer = g_valid && bus.dma_ready;

  ldmx_rr_pick #(
    .NSRC(NSRC)
  ) u_pick (
    .req       (req),
    .last_grant(grant_id),
    .pick      (pick_id),
    .any_req   (pick_any)
  );

  // Granted-source mux built by compare so grant_id may be wider than log2(NSRC).
  always_comb begin
    g_sel   = '0;
    g_valid = 1'b0;
    g_data  = '0;
    g_last  = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (grant_id == GRANT_W'(i)) begin
        g_sel[i] = 1'b1;
        g_valid  = bus.src_valid[i];
        g_data   = bus.src_data[64*i +: 64];
        g_last   = bus.src_last[i];
      end
    end
  end

  always_comb begin
    bus.dma_valid = 1'b0;
    bus.dma_data  = '0;
    bus.dma_done  = 1'b0;
    bus.src_ready = '0;
    unique case (state)
      GRANT: begin
        bus.dma_valid = g_valid;
        bus.dma_data  = g_data;
        bus.dma_done  = g_last;
        bus.src_ready = g_sel & {NSRC{bus.dma_ready}};
      end
`ifdef LDMX_DAQ_ARB_TIMEOUT_EN
      ABORT: begin
        bus.dma_valid = 1'b1;
        bus.dma_data  = {ABORT_WORD[63:3], grant_id};
        bus.dma_done  = 1'b1;
      end
      DRAIN: begin
        bus.src_ready = g_sel;
      end
`endif
      default: ;
    endcase
  end

`ifdef LDMX_DAQ_ARB_TIMEOUT_EN
  logic [15:0] stall;
  logic        started;
`else
  logic unused_cfg;
  assign unused_cfg  = ^{ABORT_WORD, TIMEOUT};
  assign abort_count = '0;
`endif

  always_ff @(posedge dma_clk) begin
    if (reset) begin
      state       <= IDLE;
      grant_id    <= GRANT_W'(NSRC - 1);
      event_count <= '0;
`ifdef LDMX_DAQ_ARB_TIMEOUT_EN
      abort_count <= '0;
      stall       <= '0;
      started     <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            grant_id <= pick_id;
            state    <= GRANT;
`ifdef LDMX_DAQ_ARB_TIMEOUT_EN
            stall    <= '0;
            started  <= 1'b0;
`endif
          end
        end
        GRANT: begin
          if (xfer && g_last) begin
            event_count <= event_count + 32'd1;
            state       <= IDLE;
          end
`ifdef LDMX_DAQ_ARB_TIMEOUT_EN
          // Only a source gap after the first word counts; backpressure never does.
          if (xfer) begin
            stall   <= '0;
            started <= 1'b1;
          end else if (!g_valid && started) begin
            if (stall == 16'(TIMEOUT - 1)) begin
              state <= ABORT;
            end else begin
              stall <= stall + 16'd1;
            end
          end
`endif
        end
`ifdef LDMX_DAQ_ARB_TIMEOUT_EN
        ABORT: begin
          if (bus.dma_ready) begin
            event_count <= event_count + 32'd1;
            if (abort_count != 16'hFFFF) begin
              abort_count <= abort_count + 16'd1;
            end
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (g_valid && g_last) begin
            state <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ldmx_daq_dma_arbiter.sv
// Scoreboard bench for ldmx_daq_dma_arbiter (NSRC=4, TIMEOUT=16).
// Abort scenario runs only when LDMX_DAQ_ARB_TIMEOUT_EN is defined.
module tb_ldmx_daq_dma_arbiter;
  import ldmx_daq_pkg::*;

  localparam int unsigned NSRC = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [GRANT_W-1:0] grant_id;
  logic               busy;
  logic [31:0]        event_count;
  logic [15:0]        abort_count;

  ldmx_daq_dma_arbiter_if #(.NSRC(NSRC)) bus ();

  ldmx_daq_dma_arbiter #(
    .NSRC      (NSRC),
    .TIMEOUT   (16),
    .ABORT_WORD(64'hDEAD_BEEF_0000_0000)
  ) dut (
    .dma_clk    (clk),
    .reset      (rst),
    .bus        (bus),
    .grant_id   (grant_id),
    .busy       (busy),
    .event_count(event_count),
    .abort_count(abort_count)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [64:0] srcq [NSRC][$];
  logic [64:0] exp_q [$];

  int unsigned cyc = 0;
  int unsigned xfer_count = 0;
  int unsigned last_xfer_cyc = 0;
  int unsigned done_cyc = 0;
  logic        after_done = 1'b0;
  logic        gap_chk = 1'b0;
  logic        ready_toggle = 1'b0;
  logic [NSRC-1:0] ready_forbid = '0;
  logic        forbid_hit = 1'b0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mkword(input int unsigned src, input int unsigned ev,
                                         input int unsigned w);
    return {16'hA500 | 16'(src), 16'(ev), 16'(w), 16'h5A5A};
  endfunction

  task automatic load_event(input int unsigned src, input int unsigned ev,
                            input int unsigned nw, input bit push);
    logic [64:0] e;
    for (int unsigned w = 0; w < nw; w++) begin
      e = {(w == nw - 1), mkword(src, ev, w)};
      srcq[src].push_back(e);
      if (push) exp_q.push_back(e);
    end
  endtask

  // One clock: drive at posedge+1, sample at negedge, return at next posedge+1.
  task automatic cycle();
    logic [64:0] head;
    logic [64:0] e;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (srcq[i].size() > 0) begin
        head = srcq[i][0];
        bus.src_valid[i]          = 1'b1;
        bus.src_data[64*i +: 64] = head[63:0];
        bus.src_last[i]           = head[64];
      end else begin
        bus.src_valid[i]          = 1'b0;
        bus.src_data[64*i +: 64] = '0;
        bus.src_last[i]           = 1'b0;
      end
    end
    bus.dma_ready = ready_toggle ? cyc[0] : 1'b1;
    @(negedge clk);
    if (prev_stall) begin
      check_eq("hold_valid", bus.dma_valid, 1);
      check_eq("hold_data", bus.dma_data, prev_data);
    end
    prev_stall = bus.dma_valid && !bus.dma_ready;
    prev_data  = bus.dma_data;
    if ((bus.src_ready & ready_forbid) != '0) forbid_hit = 1'b1;
    if (bus.dma_valid && bus.dma_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_xfer", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        check_eq("data", bus.dma_data, e[63:0]);
        check_eq("done", bus.dma_done, e[64]);
        if (gap_chk && after_done) check_eq("idle_gap", 64'(cyc - done_cyc), 64'd2);
      end
      after_done = bus.dma_done;
      if (bus.dma_done) done_cyc = cyc;
      xfer_count++;
      last_xfer_cyc = cyc;
    end
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (bus.src_valid[i] && bus.src_ready[i] && srcq[i].size() > 0) begin
        head = srcq[i].pop_front();
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_until_empty(input int unsigned budget);
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    check_eq("drain_budget", 64'(exp_q.size()), 64'd0);
    cycle();
    cycle();
  endtask

  initial begin
    int unsigned base;
    int unsigned guard;
    int unsigned t2;
    bus.src_enable = '0;
    bus.src_valid  = '0;
    bus.src_data   = '0;
    bus.src_last   = '0;
    bus.dma_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_dma_valid", bus.dma_valid, 0);
    check_eq("rst_dma_done", bus.dma_done, 0);
    check_eq("rst_dma_data", bus.dma_data, 0);
    check_eq("rst_src_ready", bus.src_ready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_grant_id", grant_id, 3);
    check_eq("rst_event_count", event_count, 0);
    check_eq("rst_abort_count", abort_count, 0);
    rst = 1'b0;

    // Round robin: every source has two 3-word events queued back to back.
    bus.src_enable = 4'b1111;
    for (int unsigned ev = 0; ev < 2; ev++)
      for (int unsigned s = 0; s < NSRC; s++) load_event(s, ev, 3, 1'b1);
    gap_chk = 1'b1;
    run_until_empty(200);
    gap_chk = 1'b0;
    check_eq("rr_event_count", event_count, 8);

    // Enable mask: only sources 0 and 2 may be served.
    bus.src_enable = 4'b0101;
    ready_forbid   = 4'b1010;
    forbid_hit     = 1'b0;
    for (int unsigned ev = 2; ev < 4; ev++) begin
      load_event(0, ev, 2, 1'b1);
      load_event(1, ev, 2, 1'b0);
      load_event(2, ev, 2, 1'b1);
      load_event(3, ev, 2, 1'b0);
    end
    run_until_empty(200);
    check_eq("mask_forbidden_ready", forbid_hit, 0);
    check_eq("mask_event_count", event_count, 12);
    srcq[1].delete();
    srcq[3].delete();
    ready_forbid   = '0;
    bus.src_enable = 4'b1111;

    // Backpressure on a 5-word event, then a single-word event.
    ready_toggle = 1'b1;
    load_event(3, 4, 5, 1'b1);
    load_event(0, 5, 1, 1'b1);
    run_until_empty(200);
    ready_toggle = 1'b0;
    check_eq("bp_event_count", event_count, 14);

    // Reset during word 2 of an event.
    load_event(2, 6, 4, 1'b1);
    base  = xfer_count;
    guard = 0;
    while (xfer_count < base + 1 && guard < 50) begin
      cycle();
      guard++;
    end
    check_eq("rst_mid_first_word", 64'(xfer_count - base), 64'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_eq("rst_mid_dma_valid", bus.dma_valid, 0);
    check_eq("rst_mid_grant_id", grant_id, 3);
    check_eq("rst_mid_event_count", event_count, 0);
    check_eq("rst_mid_abort_count", abort_count, 0);
    srcq[2].delete();
    exp_q.delete();
    prev_stall = 1'b0;
    load_event(0, 7, 2, 1'b1);
    load_event(1, 7, 2, 1'b1);
    run_until_empty(100);
    check_eq("post_rst_event_count", event_count, 2);

`ifdef LDMX_DAQ_ARB_TIMEOUT_EN
    // Source 1 stalls after two words; expect abort, drain, then source 2.
    load_event(1, 8, 2, 1'b0);
    srcq[1][1][64] = 1'b0;
    exp_q.push_back({1'b0, mkword(1, 8, 0)});
    exp_q.push_back({1'b0, mkword(1, 8, 1)});
    base  = xfer_count;
    guard = 0;
    while (xfer_count < base + 2 && guard < 50) begin
      cycle();
      guard++;
    end
    t2 = last_xfer_cyc;
    exp_q.push_back({1'b1, 64'hDEAD_BEEF_0000_0001});
    load_event(2, 9, 2, 1'b1);
    guard = 0;
    while (xfer_count < base + 3 && guard < 60) begin
      cycle();
      guard++;
    end
    check_eq("abort_latency", 64'(last_xfer_cyc - t2), 64'd17);
    srcq[1].push_back({1'b0, mkword(1, 8, 2)});
    srcq[1].push_back({1'b0, mkword(1, 8, 3)});
    srcq[1].push_back({1'b1, mkword(1, 8, 4)});
    run_until_empty(100);
    check_eq("abort_count", abort_count, 1);
    check_eq("drained_words_left", 64'(srcq[1].size()), 64'd0);
    check_eq("abort_event_count", event_count, 4);
`else
    check_eq("abort_count_tied", abort_count, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

endmodule
